display_scan_ctrl: RTL and testbench

Time-multiplexes N BCD digits onto a single shared 7-segment decoder and a common-cathode/anode segment bus. Sequences digit slots with a dead-time blank per slot to suppress ghosting, and applies leading-zero suppression. Accepts new display values through a valid/ready handshake and commits them only at frame boundaries, so a frame never shows a mix of old and new digits. Sits between the counter/datapath logic and the 4-bit-in decoder (active-low segments; inputs 10-15 blank).

---
 rtl/display_scan_ctrl_pkg.sv | 28 ++
 rtl/display_scan_ctrl_if.sv | 23 ++
 rtl/display_scan_ctrl_scan_timer.sv | 52 +++++
 rtl/display_scan_ctrl.sv | 129 ++++++++++++
 tb/tb_display_scan_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
package disp_pkg;

  localparam int MaxDigits = 8;

  typedef logic [3:0] bcd_t;
  localparam bcd_t BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

  // Bit i set when digit i (i != 0) and everything above it is a zero without a dp.
  function automatic logic [MaxDigits-1:0] lz_mask(input logic [4*MaxDigits-1:0] digits,
                                                   input logic [MaxDigits-1:0]   dps,
                                                   input int                     n);
    logic                 zero_run;
    logic [MaxDigits-1:0] mask;
    zero_run = 1'b1;
    mask     = '0;
    for (int i = MaxDigits - 1; i >= 1; i--) begin
      if (i < n) begin
        zero_run = zero_run & (digits[4*i +: 4] == 4'd0) & ~dps[i];
        mask[i]  = zero_run;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Load handshake and display bus between the datapath, scan controller and decoder.
interface display_scan_ctrl_if #(
  parameter int unsigned N_DIGITS = 4
) ();
  logic                  load_valid;
  logic                  load_ready;
  logic [4*N_DIGITS-1:0] load_data;
  logic [N_DIGITS-1:0]   load_dp;
  logic [3:0]            digit_code;
  logic [N_DIGITS-1:0]   digit_sel_n;
  logic                  dp_n;
  logic                  frame_tick;

  modport master (
    output load_valid, load_data, load_dp,
    input  load_ready, digit_code, digit_sel_n, dp_n, frame_tick
  );

  modport slave (
    input  load_valid, load_data, load_dp,
    output load_ready, digit_code, digit_sel_n, dp_n, frame_tick
  );
endinterface

// File: rtl/display_scan_ctrl_scan_timer.sv
// Per-slot prescale counter and slot index; held at zero whenever scanning is stopped.
module scan_timer #(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned SlotW    = 2,
  parameter int unsigned CntW     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  output logic [CntW-1:0]  cnt_o,
  output logic [SlotW-1:0] slot_nxt_o,
  output logic             slot_end_o,
  output logic             frame_end_o
);

  localparam logic [CntW-1:0]  CntLast  = CntW'(PRESCALE - 1);
  localparam logic [SlotW-1:0] SlotLast = SlotW'(N_DIGITS - 1);

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [SlotW-1:0] slot_q, slot_d;

  always_comb begin
    cnt_d  = cnt_q;
    slot_d = slot_q;
    if (!run_i) begin
      cnt_d  = '0;
      slot_d = '0;
    end else if (slot_end_o) begin
      cnt_d  = '0;
      slot_d = (slot_q == SlotLast) ? '0 : slot_q + SlotW'(1);
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign slot_end_o  = (cnt_q == CntLast);
  assign frame_end_o = slot_end_o && (slot_q == SlotLast);
  assign cnt_o       = cnt_q;
  assign slot_nxt_o  = slot_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      slot_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Scans N BCD digits onto a shared decoder with per-slot dead time, leading-zero
// suppression and frame-aligned commit of values loaded over a valid/ready handshake.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter bit          LZ_SUPPRESS  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  display_scan_ctrl_if.slave  bus
);

  localparam int unsigned SlotW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned CntW  = $clog2(PRESCALE);

  state_e                state_q, state_d;
  logic [4*N_DIGITS-1:0] act_q, act_d, pend_q, pend_d;
  logic [N_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                  pend_v_q, pend_v_d;
  logic                  ready_q;
  bcd_t                  code_q, code_d;
  logic [N_DIGITS-1:0]   sel_n_q, sel_n_d;
  logic                  dp_n_q, dp_n_d, tick_q, tick_d;

  logic [CntW-1:0]      cnt;
  logic [SlotW-1:0]     slot_nxt;
  logic                 slot_end, frame_end, commit, wrap;
  logic [MaxDigits-1:0] lz;

  scan_timer #(
    .N_DIGITS (N_DIGITS),
    .PRESCALE (PRESCALE),
    .SlotW    (SlotW),
    .CntW     (CntW)
  ) u_scan_timer (
    .clk         (clk),
    .rst         (rst),
    .run_i       (enable && (state_q != StIdle)),
    .cnt_o       (cnt),
    .slot_nxt_o  (slot_nxt),
    .slot_end_o  (slot_end),
    .frame_end_o (frame_end)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (enable) state_d = StBlank;
      StBlank: if (cnt == CntW'(BLANK_CYCLES - 1)) state_d = StShow;
      StShow:  if (slot_end) state_d = StBlank;
      default: state_d = StIdle;
    endcase
    if (!enable) state_d = StIdle;
  end

  // Pending only lands between frames (or at once when dark), so a frame never mixes values.
  always_comb begin
    commit    = pend_v_q && ((state_q == StIdle) || ((state_q == StShow) && frame_end));
    wrap      = enable && (state_q == StShow) && frame_end;
    act_d     = act_q;
    act_dp_d  = act_dp_q;
    pend_d    = pend_q;
    pend_dp_d = pend_dp_q;
    pend_v_d  = pend_v_q;
    if (commit) begin
      act_d    = pend_q;
      act_dp_d = pend_dp_q;
      pend_v_d = 1'b0;
    end
    if (bus.load_valid && !pend_v_q) begin
      pend_d    = bus.load_data;
      pend_dp_d = bus.load_dp;
      pend_v_d  = 1'b1;
    end
  end

  // Outputs are precomputed from next-state values so they line up with the registered state.
  always_comb begin
    lz      = LZ_SUPPRESS ? lz_mask(32'(act_d), 8'(act_dp_d), int'(N_DIGITS)) : '0;
    code_d  = BLANK_CODE;
    sel_n_d = '1;
    dp_n_d  = 1'b1;
    tick_d  = wrap;
    if (state_d != StIdle) begin
      code_d = lz[3'(slot_nxt)] ? BLANK_CODE : act_d[slot_nxt*4 +: 4];
      dp_n_d = ~act_dp_d[slot_nxt];
      if (state_d == StShow) sel_n_d = ~(N_DIGITS'(1) << slot_nxt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      act_q     <= '0;
      act_dp_q  <= '0;
      pend_q    <= '0;
      pend_dp_q <= '0;
      pend_v_q  <= 1'b0;
      ready_q   <= 1'b1;
      code_q    <= BLANK_CODE;
      sel_n_q   <= '1;
      dp_n_q    <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      act_q     <= act_d;
      act_dp_q  <= act_dp_d;
      pend_q    <= pend_d;
      pend_dp_q <= pend_dp_d;
      pend_v_q  <= pend_v_d;
      ready_q   <= ~pend_v_d;
      code_q    <= code_d;
      sel_n_q   <= sel_n_d;
      dp_n_q    <= dp_n_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.load_ready  = ready_q;
  assign bus.digit_code  = code_q;
  assign bus.digit_sel_n = sel_n_q;
  assign bus.dp_n        = dp_n_q;
  assign bus.frame_tick  = tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench: time-based reference model checked every cycle, plus directed literals.
module tb_display_scan_ctrl;
  localparam int N  = 4;
  localparam int P  = 8;
  localparam int BC = 2;
  localparam int FR = N * P;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;

  display_scan_ctrl_if #(.N_DIGITS(N)) bus ();

  display_scan_ctrl #(
    .N_DIGITS     (N),
    .PRESCALE     (P),
    .BLANK_CYCLES (BC),
    .LZ_SUPPRESS  (1'b1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: scanning time since the first blank cycle, plus active/pending values.
  bit          m_run;
  int          m_t;
  logic [15:0] m_act, m_pd;
  logic [3:0]  m_adp, m_pdp;
  bit          m_pv;

  always @(posedge clk) begin
    bit          en, lv, commit, sup;
    logic [15:0] ld;
    logic [3:0]  ldp, e_code, e_sel;
    logic        e_dp, e_tick;
    int          slot;
    en  = enable;
    lv  = bus.load_valid;
    ld  = bus.load_data;
    ldp = bus.load_dp;
    if (rst) begin
      m_run = 0; m_t = 0; m_act = '0; m_adp = '0; m_pd = '0; m_pdp = '0; m_pv = 0;
    end else begin
      commit = m_pv && (!m_run || (m_t % FR == FR - 1));
      if (commit) begin
        m_act = m_pd; m_adp = m_pdp; m_pv = 0;
      end else if (lv && !m_pv) begin
        m_pd = ld; m_pdp = ldp; m_pv = 1;
      end
      if (!en) begin
        m_run = 0; m_t = 0;
      end else if (!m_run) begin
        m_run = 1; m_t = 0;
      end else begin
        m_t++;
      end
    end
    #1;
    e_code = 4'hF; e_sel = 4'hF; e_dp = 1'b1; e_tick = 1'b0;
    if (m_run) begin
      slot = (m_t / P) % N;
      sup  = (slot != 0);
      for (int j = slot; j < N; j++)
        if (m_act[j*4 +: 4] != 4'd0 || m_adp[j]) sup = 0;
      e_code = sup ? 4'hF : m_act[slot*4 +: 4];
      e_dp   = ~m_adp[slot];
      e_sel  = (m_t % P < BC) ? 4'hF : ~(4'b0001 << slot);
      e_tick = (m_t > 0) && (m_t % FR == 0);
    end
    chk("model_code", 32'(bus.digit_code), 32'(e_code));
    chk("model_sel", 32'(bus.digit_sel_n), 32'(e_sel));
    chk("model_dp", 32'(bus.dp_n), 32'(e_dp));
    chk("model_tick", 32'(bus.frame_tick), 32'(e_tick));
    chk("model_ready", 32'(bus.load_ready), 32'(!m_pv));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick();
    for (int k = 0; k < 4 * FR; k++) begin
      @(negedge clk);
      if (bus.frame_tick) break;
    end
    chk("frame_tick_seen", 32'(bus.frame_tick), 32'd1);
  endtask

  function automatic logic [15:0] rnd_bcd();
    logic [15:0] d;
    for (int i = 0; i < N; i++)
      d[i*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    return d;
  endfunction

  initial begin
    int nx;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_dp    = '0;
    step(3);
    rst = 1'b0;
    chk("rst_ready", 32'(bus.load_ready), 32'd1);
    chk("rst_code", 32'(bus.digit_code), 32'hF);
    chk("rst_sel", 32'(bus.digit_sel_n), 32'hF);
    chk("rst_dp", 32'(bus.dp_n), 32'd1);
    chk("rst_tick", 32'(bus.frame_tick), 32'd0);

    // Empty display: slot 0 shows "0", upper slots blank.
    enable = 1'b1;
    step(1);
    chk("zero_slot0_code", 32'(bus.digit_code), 32'h0);
    chk("zero_slot0_blank", 32'(bus.digit_sel_n), 32'hF);
    step(2);
    chk("zero_slot0_show", 32'(bus.digit_sel_n), 32'hE);
    step(6);
    chk("zero_slot1_lz", 32'(bus.digit_code), 32'hF);
    wait_tick();
    step(1);
    chk("tick_one_cycle", 32'(bus.frame_tick), 32'd0);
    enable = 1'b0;
    step(2);

    // Load while dark commits immediately.
    bus.load_valid = 1'b1; bus.load_data = 16'h1234; bus.load_dp = 4'b0000;
    step(1);
    chk("idle_load_busy", 32'(bus.load_ready), 32'd0);
    bus.load_valid = 1'b0;
    step(1);
    chk("idle_load_ready", 32'(bus.load_ready), 32'd1);
    enable = 1'b1;
    step(1);  chk("v1234_s0", 32'(bus.digit_code), 32'h4);
    step(8);  chk("v1234_s1", 32'(bus.digit_code), 32'h3);
    step(8);  chk("v1234_s2", 32'(bus.digit_code), 32'h2);
    step(8);  chk("v1234_s3", 32'(bus.digit_code), 32'h1);

    // Mid-frame load waits for the boundary.
    bus.load_valid = 1'b1; bus.load_data = 16'h0056;
    step(1);
    chk("mid_load_busy", 32'(bus.load_ready), 32'd0);
    bus.load_valid = 1'b0;
    step(2);
    chk("mid_old_kept", 32'(bus.digit_code), 32'h1);
    wait_tick();
    chk("v0056_s0", 32'(bus.digit_code), 32'h6);
    step(1);  chk("ready_after_tick", 32'(bus.load_ready), 32'd1);
    step(7);  chk("v0056_s1", 32'(bus.digit_code), 32'h5);
    step(8);  chk("v0056_s2_lz", 32'(bus.digit_code), 32'hF);

    // valid held with changing data: one transfer per frame.
    bus.load_valid = 1'b1;
    wait_tick();
    nx = 0;
    for (int c = 0; c < 4 * FR; c++) begin
      if (bus.load_ready) nx++;
      bus.load_data = rnd_bcd();
      bus.load_dp   = 4'($urandom_range(0, 15));
      step(1);
    end
    chk("xfers_per_4_frames", 32'(nx), 32'd4);
    bus.load_valid = 1'b0;

    // Decimal point on a zero digit stops suppression below it.
    enable = 1'b0;
    step(2);
    bus.load_valid = 1'b1; bus.load_data = 16'h0000; bus.load_dp = 4'b0100;
    step(1);
    bus.load_valid = 1'b0;
    step(1);
    enable = 1'b1;
    step(1);  chk("dp_s0_code", 32'(bus.digit_code), 32'h0);
              chk("dp_s0_dp", 32'(bus.dp_n), 32'd1);
    step(8);  chk("dp_s1_code", 32'(bus.digit_code), 32'h0);
    step(8);  chk("dp_s2_code", 32'(bus.digit_code), 32'h0);
              chk("dp_s2_dp", 32'(bus.dp_n), 32'd0);
    step(8);  chk("dp_s3_code", 32'(bus.digit_code), 32'hF);
              chk("dp_s3_dp", 32'(bus.dp_n), 32'd1);

    // Drop enable during slot 2 SHOW.
    wait_tick();
    step(19);
    chk("s2_show_sel", 32'(bus.digit_sel_n), 32'hB);
    enable = 1'b0;
    step(1);
    chk("disable_sel", 32'(bus.digit_sel_n), 32'hF);
    chk("disable_code", 32'(bus.digit_code), 32'hF);
    enable = 1'b1;
    step(1);
    chk("reenable_sel", 32'(bus.digit_sel_n), 32'hF);
    chk("reenable_code", 32'(bus.digit_code), 32'h0);
    step(2);
    chk("reenable_slot0", 32'(bus.digit_sel_n), 32'hE);

    // Async reset mid-SHOW discards the pending value.
    step(18);
    bus.load_valid = 1'b1; bus.load_data = 16'h9999; bus.load_dp = 4'b0000;
    step(1);
    chk("pre_rst_busy", 32'(bus.load_ready), 32'd0);
    bus.load_valid = 1'b0;
    step(1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_sel", 32'(bus.digit_sel_n), 32'hF);
    chk("async_rst_code", 32'(bus.digit_code), 32'hF);
    chk("async_rst_ready", 32'(bus.load_ready), 32'd1);
    step(2);
    rst = 1'b0;
    step(1);
    chk("post_rst_code", 32'(bus.digit_code), 32'h0);
    step(8);
    chk("post_rst_lz", 32'(bus.digit_code), 32'hF);

    // Random traffic with occasional enable drops and resets.
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      else if (!enable && $urandom_range(0, 9) == 0) enable = 1'b1;
      bus.load_valid = ($urandom_range(0, 3) == 0);
      bus.load_data  = rnd_bcd();
      bus.load_dp    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      rst = ($urandom_range(0, 599) == 0);
      step(1);
    end
    rst = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
